imu_frame_scheduler: RTL and testbench

Frame scheduler that shares the byte-wide UART transmitter between the three 32-bit IMU result channels: gyro rate, accelerometer tilt angle and filtered angle. A period timer starts a burst in which each enabled channel is sent as one 7-byte frame, in channel order. Each byte is handed to the transmitter over the `is_send`/`is_done` handshake. The block sits between the calculation blocks and the UART transmitter.

---
 rtl/imu_pkg.sv | 43 ++++
 rtl/period_tick.sv | 32 +++
 rtl/imu_frame_scheduler.sv | 160 ++++++++++++++++
 tb/tb_imu_frame_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_pkg.sv
// Shared state encoding, frame constants and byte selection for the IMU frame scheduler.
package imu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned FRAME_LEN = 7;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned WORD_W    = 32;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [7:0] CH_ID_GYRO     = 8'h01;
  localparam logic [7:0] CH_ID_TILT     = 8'h02;
  localparam logic [7:0] CH_ID_FILTERED = 8'h03;
  localparam logic [7:0] DEFAULT_HEADER = 8'h55;

  // Payload byte at frame position idx (1 = ID, 2..5 = word MSB first); header/checksum handled by caller.
  function automatic logic [7:0] data_byte(input logic [IDX_W-1:0] idx,
                                           input logic [1:0]       ch,
                                           input logic [WORD_W-1:0] word);
    logic [7:0] id;
    case (ch)
      2'd0:    id = CH_ID_GYRO;
      2'd1:    id = CH_ID_TILT;
      default: id = CH_ID_FILTERED;
    endcase
    case (idx)
      3'd1:    return id;
      3'd2:    return word[31:24];
      3'd3:    return word[23:16];
      3'd4:    return word[15:8];
      3'd5:    return word[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/period_tick.sv
// Free-running 0..PERIOD counter that emits a one-cycle registered tick when the count equals PERIOD.
module period_tick #(
  parameter int unsigned         CNT_W  = 32,
  parameter logic [CNT_W-1:0]    PERIOD = CNT_W'(4999999)
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q tracks (cnt_q == PERIOD) by registering the comparison on the next count.
  always_comb begin
    cnt_d  = (cnt_q == PERIOD) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == PERIOD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= (PERIOD == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/imu_frame_scheduler.sv
// Periodic burst scheduler: serialises each enabled IMU channel as a 7-byte frame
// through the UART transmitter's is_send/is_done byte handshake.
module imu_frame_scheduler
  import imu_pkg::*;
#(
  parameter logic [31:0] PERIOD  = 32'd4999999,
  parameter logic [7:0]  HEADER  = DEFAULT_HEADER,
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_W-1:0]   data0,
  input  logic [WORD_W-1:0]   data1,
  input  logic [WORD_W-1:0]   data2,
  input  logic [NUM_CH-1:0]   ch_en,
  output logic [7:0]          uart_data,
  output logic                is_send,
  input  logic                is_done,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned TO_W = 20;

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0][WORD_W-1:0]  snap_q, snap_d;
  logic [NUM_CH-1:0]              mask_q, mask_d;
  logic [1:0]                     ch_q, ch_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [7:0]                     csum_q, csum_d;
  logic [TO_W-1:0]                tcnt_q, tcnt_d;
  logic [7:0]                     uart_data_q, uart_data_d;
  logic                           is_send_q, is_send_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;
  logic                           timeout_err_q, timeout_err_d;

  logic                           tick;
  logic [WORD_W-1:0]              cur_word;
  logic [IDX_W-1:0]               nxt_idx;
  logic [7:0]                     nxt_byte;

  period_tick #(
    .CNT_W  (32),
    .PERIOD (PERIOD)
  ) u_period_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  always_comb begin
    case (ch_q)
      2'd0:    cur_word = snap_q[0];
      2'd1:    cur_word = snap_q[1];
      default: cur_word = snap_q[2];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    mask_d        = mask_q;
    ch_d          = ch_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    tcnt_d        = tcnt_q;
    uart_data_d   = uart_data_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q | (tick && (state_q != S_IDLE));
    nxt_idx       = idx_q + IDX_W'(1);
    nxt_byte      = data_byte(nxt_idx, ch_q, cur_word);

    unique case (state_q)
      S_IDLE: begin
        if (tick && (ch_en != '0)) begin
          snap_d  = {data2, data1, data0};
          mask_d  = ch_en;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Lowest pending channel first; mask & (mask-1) drops exactly that bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (mask_q[i]) ch_d = 2'(i);
        end
        mask_d      = mask_q & (mask_q - NUM_CH'(1));
        idx_d       = '0;
        csum_d      = '0;
        uart_data_d = HEADER;
        state_d     = S_SEND;
      end
      S_SEND: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (is_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d       = nxt_idx;
            uart_data_d = (nxt_idx == LAST_IDX) ? csum_q : nxt_byte;
            csum_d      = csum_q + nxt_byte;
            state_d     = S_SEND;
          end else if (mask_q != '0) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tcnt_q == TIMEOUT - TO_W'(1)) begin
          timeout_err_d = 1'b1;
          mask_d        = '0;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
    endcase

    is_send_d = (state_d == S_SEND);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      snap_q        <= '0;
      mask_q        <= '0;
      ch_q          <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      tcnt_q        <= '0;
      uart_data_q   <= '0;
      is_send_q     <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      mask_q        <= mask_d;
      ch_q          <= ch_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      tcnt_q        <= tcnt_d;
      uart_data_q   <= uart_data_d;
      is_send_q     <= is_send_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign uart_data   = uart_data_q;
  assign is_send     = is_send_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_imu_frame_scheduler.sv
// Self-checking bench for imu_frame_scheduler: transmitter model, byte monitor and frame reference model.
module tb_imu_frame_scheduler;

  localparam int P  = 50;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data0, data1, data2;
  logic [2:0]  ch_en;
  logic [7:0]  uart_data;
  logic        is_send, is_done, busy, overrun, timeout_err;

  int          n_chk = 0;
  int          n_fail = 0;
  int          lat = 3;
  bit          spur = 1'b0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];

  imu_frame_scheduler #(
    .PERIOD  (32'(P)),
    .HEADER  (8'h55),
    .TIMEOUT (20'(TO))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .ch_en       (ch_en),
    .uart_data   (uart_data),
    .is_send     (is_send),
    .is_done     (is_done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model plus byte monitor; is_done is driven for the cycle that follows this negedge.
  initial begin : xmit_mon
    int         pend;
    logic [7:0] held;
    bit         in_flight, sent_last;
    pend = 0; held = '0; in_flight = 1'b0; sent_last = 1'b0; is_done = 1'b0;
    forever begin
      @(negedge clk);
      if (in_flight && is_done && !sent_last) in_flight = 1'b0;
      sent_last = 1'b0;
      if (!busy) in_flight = 1'b0;
      if (in_flight) begin
        n_chk++;
        if (uart_data !== held) begin
          n_fail++;
          $display("FAIL uart_data_stable: got %h, required %h until is_done", uart_data, held);
        end
      end
      if (is_send) begin
        got.push_back(uart_data);
        held = uart_data; in_flight = 1'b1; sent_last = 1'b1;
      end
      is_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) is_done = 1'b1;
      end
      if (is_send) begin
        if (lat > 0) pend = lat;
        if (spur) is_done = 1'b1;
      end else if (spur && !busy && ($urandom_range(0, 3) == 0)) begin
        is_done = 1'b1;
      end
    end
  end

  // Reference: one frame per enabled channel in ascending order, checksum = (ID + data bytes) mod 256.
  function automatic void build_exp(input logic [2:0] en, input logic [31:0] d0, d1, d2);
    logic [31:0] w;
    int          sum;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      if (!en[c]) continue;
      w   = (c == 0) ? d0 : ((c == 1) ? d1 : d2);
      sum = c + 1;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'(c + 1));
      for (int b = 3; b >= 0; b--) begin
        sum += int'((w >> (8 * b)) & 32'hFF);
        exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
      end
      exp_q.push_back(8'(sum % 256));
    end
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_send(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!is_send && n < 500);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 500);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk += 5;
    if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_uart_data: got %h, required 00", uart_data); end
    if (is_send !== 1'b0) begin n_fail++; $display("FAIL reset_is_send: got %b, required 0", is_send); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b, required 0", timeout_err); end
  endtask

  task automatic test_single_channel();
    int n;
    data0 = 32'h12345678; data1 = $urandom; data2 = $urandom; ch_en = 3'b001; lat = 3;
    do_reset(); got.delete();
    wait_send(n);
    n_chk += 2;
    if (n != P + 2) begin n_fail++; $display("FAIL single_first_send_cycle: got %0d, required %0d", n, P + 2); end
    if (uart_data !== 8'h55) begin n_fail++; $display("FAIL single_header: got %h, required 55", uart_data); end
    wait_idle(n);
    n_chk += 3;
    if (n != 28) begin n_fail++; $display("FAIL single_burst_len: got %0d, required 28", n); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b, required 0", overrun); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL single_timeout_err: got %b, required 0", timeout_err); end
    exp_q = {8'h55, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
    n_chk++;
    if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d, required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h, required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_two_channel();
    int n;
    data0 = 32'h0; data1 = $urandom; data2 = 32'hFFFFFFFF; ch_en = 3'b101; lat = 3;
    do_reset(); got.delete();
    wait_send(n);
    wait_idle(n);
    n_chk++;
    if (n != 57) begin n_fail++; $display("FAIL two_burst_len: got %0d, required 57", n); end
    exp_q = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
             8'h55, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    n_chk++;
    if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL two_count: got %0d, required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_byte%0d: got %h, required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int n, hits;
    for (int it = 0; it < 8; it++) begin
      data0 = $urandom; data1 = $urandom; data2 = $urandom;
      ch_en = 3'($urandom_range(0, 7)); lat = $urandom_range(1, 3);
      build_exp(ch_en, data0, data1, data2);
      do_reset(); got.delete();
      if (ch_en == 3'b000) begin
        hits = 0;
        for (int k = 0; k < 120; k++) begin
          @(negedge clk);
          if (is_send || busy) hits++;
        end
        n_chk++;
        if (hits != 0) begin n_fail++; $display("FAIL rand%0d_empty_mask: got %0d active cycles, required 0", it, hits); end
      end else begin
        wait_send(n);
        data0 = $urandom; data1 = $urandom; data2 = $urandom; ch_en = 3'($urandom);
        wait_idle(n);
        n_chk += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle: got busy %b, required 0", it, busy); end
        if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d, required %0d", it, got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
          n_chk++;
          if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h, required %h", it, i, got[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int sends;
    data0 = $urandom; data1 = $urandom; data2 = $urandom; ch_en = 3'b111; lat = 3;
    build_exp(ch_en, data0, data1, data2);
    do_reset(); got.delete();
    sends = 0;
    for (int n = 1; n <= 2 * (P + 1) + 52; n++) begin
      @(negedge clk);
      if (n == 2 * (P + 1) - 1) begin
        n_chk++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %b, required 0", overrun); end
      end
      if (n == 2 * (P + 1)) begin
        n_chk++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", overrun); end
      end
      if (n == 2 * (P + 1) + 52) begin
        n_chk++;
        if (is_send !== 1'b1 || uart_data !== 8'h55) begin
          n_fail++; $display("FAIL overrun_next_burst: got is_send %b data %h, required 1 55", is_send, uart_data);
        end
      end else if (is_send) begin
        sends++;
      end
    end
    @(negedge clk);
    n_chk++;
    if (sends != 21) begin n_fail++; $display("FAIL overrun_one_burst: got %0d sends, required 21", sends); end
    for (int i = 0; i < 21 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL overrun_byte%0d: got %h, required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    data0 = $urandom; ch_en = 3'b001; lat = -1;
    do_reset(); got.delete();
    wait_send(n);
    for (int k = 1; k <= TO; k++) @(negedge clk);
    n_chk += 2;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b, required 0", timeout_err); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_wait_busy: got %b, required 1", busy); end
    @(negedge clk);
    n_chk += 2;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b, required 1", timeout_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy %b, required 0", busy); end
    wait_send(n);
    n_chk += 3;
    if (n != 30) begin n_fail++; $display("FAIL timeout_next_burst_cycle: got %0d, required 30", n); end
    if (uart_data !== 8'h55) begin n_fail++; $display("FAIL timeout_next_header: got %h, required 55", uart_data); end
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", timeout_err); end
  endtask

  task automatic test_timeout_coincident();
    int n;
    data0 = $urandom; ch_en = 3'b001; lat = TO;
    build_exp(ch_en, data0, data1, data2);
    do_reset(); got.delete();
    wait_send(n);
    wait_idle(n);
    n_chk += 3;
    if (n != 147) begin n_fail++; $display("FAIL coincide_burst_len: got %0d, required 147", n); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL coincide_timeout_err: got %b, required 0", timeout_err); end
    if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL coincide_count: got %0d, required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL coincide_byte%0d: got %h, required %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int n, sends;
    data0 = $urandom; ch_en = 3'b001; lat = 3;
    do_reset(); got.delete();
    sends = 0; n = 0;
    while (sends < 4 && n < 500) begin
      @(negedge clk); n++;
      if (is_send) sends++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk += 5;
    if (uart_data !== 8'h00) begin n_fail++; $display("FAIL midrst_uart_data: got %h, required 00", uart_data); end
    if (is_send !== 1'b0) begin n_fail++; $display("FAIL midrst_is_send: got %b, required 0", is_send); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b, required 0", overrun); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout_err: got %b, required 0", timeout_err); end
    rst = 1'b0;
    wait_send(n);
    n_chk += 2;
    if (n != P + 2) begin n_fail++; $display("FAIL midrst_next_send: got %0d, required %0d", n, P + 2); end
    if (uart_data !== 8'h55) begin n_fail++; $display("FAIL midrst_header: got %h, required 55", uart_data); end
  endtask

  task automatic test_spurious();
    int n;
    data0 = $urandom; data1 = $urandom; data2 = $urandom; ch_en = 3'b111; lat = 2; spur = 1'b1;
    build_exp(ch_en, data0, data1, data2);
    do_reset(); got.delete();
    wait_send(n);
    wait_idle(n);
    spur = 1'b0;
    n_chk++;
    if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL spur_count: got %0d, required %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL spur_byte%0d: got %h, required %h", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; data0 = '0; data1 = '0; data2 = '0; ch_en = '0;
    test_reset();
    test_single_channel();
    test_two_channel();
    test_random();
    test_overrun();
    test_timeout();
    test_timeout_coincident();
    test_reset_mid_burst();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
